// File: rtl/board_pkg.sv
// Shared checkerboard definitions: cell encodings, board geometry and the
// scanner state encoding. The memory reset block uses CELL_EMPTY from here.
package board_pkg;

    localparam int BOARD_ADDR_W = 6;
    localparam int BOARD_DEPTH  = 64;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/board_state_scanner.sv
// Sweeps every cell of the checkerboard state RAM through its asynchronous
// read port, streams each cell out on a valid/ready interface and keeps
// per-colour counts. Level enable in, sticky done out, matching the memory
// reset block so the controller can sequence both the same way.
module board_state_scanner
    import board_pkg::*;
#(
    parameter int ADDR_W = BOARD_ADDR_W,
    parameter int DEPTH  = BOARD_DEPTH,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_data,
    output logic [CNT_W-1:0]  cnt_empty,
    output logic [CNT_W-1:0]  cnt_black,
    output logic [CNT_W-1:0]  cnt_white,
    output logic              bad_cell,
    output logic              done
);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [1:0]        out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_empty_q, cnt_empty_d;
    logic [CNT_W-1:0]  cnt_black_q, cnt_black_d;
    logic [CNT_W-1:0]  cnt_white_q, cnt_white_d;
    logic              bad_q, bad_d;
    logic              fetch;

    // Next-state, fetch/accept decisions and the RAM read address.
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        valid_d     = valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        cnt_empty_d = cnt_empty_q;
        cnt_black_d = cnt_black_q;
        cnt_white_d = cnt_white_q;
        bad_d       = bad_q;
        rd_addr     = '0;
        fetch       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start of a scan clears everything gathered by the last one.
                if (en) begin
                    state_d     = ST_SCAN;
                    addr_d      = '0;
                    last_d      = 1'b0;
                    cnt_empty_d = '0;
                    cnt_black_d = '0;
                    cnt_white_d = '0;
                    bad_d       = 1'b0;
                end
            end

            ST_SCAN: begin
                rd_addr = addr_q;
                if (!en) begin
                    // Abort: drop the pending beat, keep partial counts.
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    // Load a new cell when the output register is free or
                    // being drained this cycle, until the last cell is out.
                    fetch = !last_q && (!valid_q || out_ready);
                    if (fetch) begin
                        out_data_d = rd_data;
                        out_addr_d = addr_q;
                        valid_d    = 1'b1;
                        case (rd_data)
                            CELL_EMPTY: cnt_empty_d = cnt_empty_q + CNT_W'(1);
                            CELL_BLACK: cnt_black_d = cnt_black_q + CNT_W'(1);
                            CELL_WHITE: cnt_white_d = cnt_white_q + CNT_W'(1);
                            default:    bad_d       = 1'b1;
                        endcase
                        if (addr_q == ADDR_W'(DEPTH - 1)) begin
                            last_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else if (valid_q && out_ready && last_q) begin
                        // Final beat accepted with nothing left to fetch.
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                valid_d = 1'b0;
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            cnt_empty_q <= '0;
            cnt_black_q <= '0;
            cnt_white_q <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            cnt_empty_q <= cnt_empty_d;
            cnt_black_q <= cnt_black_d;
            cnt_white_q <= cnt_white_d;
            bad_q       <= bad_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign cnt_empty = cnt_empty_q;
    assign cnt_black = cnt_black_q;
    assign cnt_white = cnt_white_q;
    assign bad_cell  = bad_q;
    assign done      = (state_q == ST_DONE);

    // Each cell bumps at most one counter once per scan, so the total can
    // never pass the board size; no saturation is built in.
    logic [CNT_W+1:0] cnt_sum;
    assign cnt_sum = {2'b00, cnt_empty_q} + {2'b00, cnt_black_q} + {2'b00, cnt_white_q};

    cnt_bound_a: assert property (@(posedge clk) disable iff (rst)
        cnt_sum <= (CNT_W + 2)'(DEPTH));

endmodule
